uart_key_rx: RTL

- Receive side of the piano's serial key link.
- Deserialises 8N1 UART frames (start 0, 8 data LSB-first, stop 1) from an async line and validates framing.
- Decodes the ASCII note code into a one-hot 13-bit key vector of the same form the key module consumes.
- Sits between the board RX pin and the key/note logic, so a host or second board can "press" keys remotely.

---
 rtl/uart_key_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_key_rx.sv
// rtl/uart_key_rx.sv - 8N1 UART receiver that decodes note codes into a held one-hot key vector
module uart_key_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HOLD_CYCLES  = 5000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rxd,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        unknown_code,
    output logic [12:0] keyboard
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic              rxd_meta_q, rxd_s_q;
    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              unknown_q, unknown_d;
    logic [12:0]       kb_q, kb_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              key_hit;
    logic [12:0]       key_vec;

    always_comb begin
        key_hit = 1'b1;
        key_vec = 13'h0000;
        case (shift_q)
            8'h43:   key_vec = 13'h0001;
            8'h63:   key_vec = 13'h0002;
            8'h44:   key_vec = 13'h0004;
            8'h64:   key_vec = 13'h0008;
            8'h45:   key_vec = 13'h0010;
            8'h46:   key_vec = 13'h0020;
            8'h66:   key_vec = 13'h0040;
            8'h47:   key_vec = 13'h0080;
            8'h67:   key_vec = 13'h0100;
            8'h41:   key_vec = 13'h0200;
            8'h61:   key_vec = 13'h0400;
            8'h42:   key_vec = 13'h0800;
            8'h2B:   key_vec = 13'h1000;
            default: key_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        unknown_d   = 1'b0;
        kb_d        = kb_q;
        hold_d      = hold_q;

        // Hold countdown; a load in STOP below overrides the expiry clear.
        if (kb_q != 13'h0000) begin
            hold_d = hold_q - HOLD_W'(1);
            if (hold_q == HOLD_W'(1)) begin
                kb_d = 13'h0000;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!rxd_s_q) begin
                    state_d = ST_START;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                end
            end
            ST_START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    state_d = rxd_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    shift_d = {rxd_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_q == BIT_LAST) begin
                    baud_d = '0;
                    if (rxd_s_q) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = ST_IDLE;
                        if (key_hit) begin
                            kb_d   = key_vec;
                            hold_d = HOLD_LOAD;
                        end else begin
                            unknown_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_BREAK: begin
                if (rxd_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
            state_q     <= ST_IDLE;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            unknown_q   <= 1'b0;
            kb_q        <= 13'h0000;
            hold_q      <= '0;
        end else begin
            rxd_meta_q  <= rxd;
            rxd_s_q     <= rxd_meta_q;
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            unknown_q   <= unknown_d;
            kb_q        <= kb_d;
            hold_q      <= hold_d;
        end
    end

    assign rx_byte      = rx_byte_q;
    assign rx_valid     = rx_valid_q;
    assign frame_err    = frame_err_q;
    assign unknown_code = unknown_q;
    assign keyboard     = kb_q;

endmodule
